// File: rtl/niosii_rom_crc_checker.sv
// Boot-time ROM integrity checker: sweeps every ROM word through port s2, folds it into a
// CRC-32/BZIP2 and holds the CPU in reset until the result has been compared with the golden value.
module niosii_rom_crc_checker #(
   parameter int unsigned NUM_WORDS    = 2560,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter logic [31:0] EXPECTED_CRC = 32'h00000000,
   parameter bit          AUTO_START   = 1'b1,
   parameter bit          HOLD_ON_FAIL = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_chipselect,
   output logic                  rom_clken,
   input  logic [31:0]           rom_readdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [31:0]           crc_out,
   output logic                  cpu_hold
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SCAN  = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [31:0]           CRC_POLY  = 32'h04C11DB7;
   localparam logic [31:0]           CRC_INIT  = 32'hFFFFFFFF;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   // Non-reflected CRC-32 update over one full word, bit 31 (first byte's MSB) first.
   function automatic logic [31:0] crc32_fold(input logic [31:0] crc, input logic [31:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (c[31] ^ data[i]) begin
            c = {c[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  cs_q, cs_d;
   logic                  rd_valid_q;
   logic [31:0]           crc_q, crc_d;
   logic [31:0]           crc_out_q, crc_out_d;
   logic                  pass_q, pass_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  hold_q, hold_d;
   logic                  first_q;
   logic [31:0]           final_crc_s;
   logic                  match_s;

   assign final_crc_s = crc_q ^ CRC_INIT;
   assign match_s     = (final_crc_s == EXPECTED_CRC);

   // Next-state logic for the sweep FSM, address counter, CRC and result flags.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cs_d      = 1'b0;
      crc_out_d = crc_out_q;
      pass_d    = pass_q;
      done_d    = done_q;
      busy_d    = busy_q;
      hold_d    = hold_q;
      // Data returns one cycle after its address, so the fold lags the SCAN cycles by one.
      if (rd_valid_q) begin
         crc_d = crc32_fold(crc_q, rom_readdata);
      end else begin
         crc_d = crc_q;
      end
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start || ((state_q == ST_IDLE) && AUTO_START && first_q)) begin
               state_d = ST_SCAN;
               crc_d   = CRC_INIT;
               addr_d  = {ADDR_WIDTH{1'b0}};
               cs_d    = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               hold_d  = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_SCAN: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_DRAIN;
               cs_d    = 1'b0;
            end else begin
               addr_d  = addr_q + ADDR_WIDTH'(1);
               cs_d    = 1'b1;
            end
         end
         ST_DRAIN: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d   = ST_DONE;
            crc_out_d = final_crc_s;
            pass_d    = match_s;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            if (match_s || !HOLD_ON_FAIL) begin
               hold_d = 1'b0;
            end else begin
               hold_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset lands every output on its documented value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= {ADDR_WIDTH{1'b0}};
         cs_q       <= 1'b0;
         rd_valid_q <= 1'b0;
         crc_q      <= CRC_INIT;
         crc_out_q  <= 32'h00000000;
         pass_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         hold_q     <= AUTO_START;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cs_q       <= cs_d;
         rd_valid_q <= cs_q;
         crc_q      <= crc_d;
         crc_out_q  <= crc_out_d;
         pass_q     <= pass_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         hold_q     <= hold_d;
         first_q    <= 1'b0;
      end
   end

   assign rom_address    = addr_q;
   assign rom_chipselect = cs_q;
   assign rom_clken      = 1'b1;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign crc_out        = crc_out_q;
   assign cpu_hold       = hold_q;

endmodule

// File: tb/tb_niosii_rom_crc_checker.sv
// Scoreboard bench: five checker instances with different images/parameters; expected
// CRC/pass/hold/cycle entries are queued at stimulus time and retired on each done edge.
module tb_niosii_rom_crc_checker;

   localparam int          AW   = 4;
   localparam logic [31:0] POLY = 32'h04C11DB7;

   typedef struct {
      int          idx;
      logic [31:0] crc;
      logic        pass;
      logic        hold;
      int          cyc;
   } exp_t;

   function automatic int nw(input int g);
      return (g == 3) ? 1 : 4;
   endfunction

   function automatic logic [31:0] img_word(input int g, input int a);
      if (g == 3) return 32'h31323334;
      else if (g == 4) return 32'h9E3779B9 * 32'(a + 1);
      else return 32'h00000000;
   endfunction

   // Byte-at-a-time software reference of CRC-32/BZIP2 over the image of instance g.
   function automatic logic [31:0] model_crc(input int g, input int n);
      logic [31:0] c;
      logic [31:0] w;
      c = 32'hFFFFFFFF;
      for (int a = 0; a < n; a++) begin
         w = img_word(g, a);
         for (int b = 3; b >= 0; b--) begin
            c = c ^ {w[b*8 +: 8], 24'h000000};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
         end
      end
      return ~c;
   endfunction

   function automatic logic [31:0] exp_param(input int g);
      if (g == 1 || g == 2) return model_crc(0, 4) ^ 32'h00000001;
      else return model_crc(g, nw(g));
   endfunction

   logic          clk = 1'b0;
   logic          rst_a, rst_x;
   logic          start_w [5];
   logic [AW-1:0] addr_w  [5];
   logic          cs_w    [5];
   logic          clken_w [5];
   logic          busy_w  [5];
   logic          done_w  [5];
   logic          pass_w  [5];
   logic [31:0]   crc_w   [5];
   logic          hold_w  [5];

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   pushes     [5];
   int   done_edges [5];
   logic done_prev  [5];
   logic prev_cs0 = 1'b0;
   logic [AW-1:0] prev_addr0 = '0;
   int   cs_cnt3 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      logic [31:0] rd_s;
      niosii_rom_crc_checker #(
         .NUM_WORDS   (nw(g)),
         .ADDR_WIDTH  (AW),
         .EXPECTED_CRC(exp_param(g)),
         .AUTO_START  (g != 4),
         .HOLD_ON_FAIL(g != 2)
      ) u_dut (
         .clk           (clk),
         .reset         ((g == 0) ? rst_a : rst_x),
         .start         (start_w[g]),
         .rom_address   (addr_w[g]),
         .rom_chipselect(cs_w[g]),
         .rom_clken     (clken_w[g]),
         .rom_readdata  (rd_s),
         .busy          (busy_w[g]),
         .done          (done_w[g]),
         .pass          (pass_w[g]),
         .crc_out       (crc_w[g]),
         .cpu_hold      (hold_w[g])
      );
      // 1-cycle ROM; garbage is returned whenever the checker is not reading
      always @(posedge clk) rd_s <= cs_w[g] ? img_word(g, int'(addr_w[g])) : (32'hDEADBEEF ^ 32'(cyc));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input int i, input int rel);
      exp_t e;
      e.idx  = i;
      e.crc  = model_crc(i, nw(i));
      e.pass = !(i == 1 || i == 2);
      e.hold = (i == 1);
      e.cyc  = rel + nw(i) + 3;
      sb.push_back(e);
      pushes[i]++;
   endtask

   task automatic pulse(input int i, input bit expect_done);
      @(negedge clk);
      start_w[i] = 1'b1;
      if (expect_done) push(i, cyc);
      @(negedge clk);
      start_w[i] = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic wait_addr2;
      int n = 0;
      while (!(cs_w[0] && addr_w[0] == AW'(2)) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_addr2", 32'(cs_w[0] && addr_w[0] == AW'(2)), 32'd1);
   endtask

   task automatic chk_reset0;
      chk("rst_addr", 32'(addr_w[0]), 32'd0);
      chk("rst_cs",   32'(cs_w[0]),   32'd0);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_done", 32'(done_w[0]), 32'd0);
      chk("rst_pass", 32'(pass_w[0]), 32'd0);
      chk("rst_crc",  crc_w[0],       32'd0);
      chk("rst_hold", 32'(hold_w[0]), 32'd1);
   endtask

   // Retire scoreboard entries on done edges and police the address sequence of instance 0.
   always @(negedge clk) begin
      int k;
      for (int i = 0; i < 5; i++) begin
         if (done_w[i] && !done_prev[i]) begin
            done_edges[i]++;
            k = -1;
            for (int j = 0; j < sb.size(); j++) if (k < 0 && sb[j].idx == i) k = j;
            if (k >= 0) begin
               chk($sformatf("done_cyc[%0d]", i), 32'(cyc), 32'(sb[k].cyc));
               chk($sformatf("crc[%0d]", i), crc_w[i], sb[k].crc);
               chk($sformatf("pass[%0d]", i), 32'(pass_w[i]), 32'(sb[k].pass));
               chk($sformatf("hold[%0d]", i), 32'(hold_w[i]), 32'(sb[k].hold));
               sb.delete(k);
            end
         end
         done_prev[i] = done_w[i];
      end
      if (cs_w[0] && prev_cs0) chk("addr_step", 32'(addr_w[0]), 32'(prev_addr0) + 32'd1);
      if (cs_w[0] && !prev_cs0) chk("addr_first", 32'(addr_w[0]), 32'd0);
      if (!cs_w[0] && prev_cs0 && !rst_a) chk("addr_last", 32'(prev_addr0), 32'd3);
      prev_cs0   = cs_w[0];
      prev_addr0 = addr_w[0];
      if (cs_w[3]) cs_cnt3++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1;
      rst_x = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start_w[i]    = 1'b0;
         pushes[i]     = 0;
         done_edges[i] = 0;
         done_prev[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk_reset0();
      chk("rst_hold_noauto", 32'(hold_w[4]), 32'd0);
      chk("clken", 32'(clken_w[0]), 32'd1);

      // Auto-start sweeps: good zero image, bad CRC with/without hold, single word "1234"
      rst_a = 1'b0;
      rst_x = 1'b0;
      for (int i = 0; i < 4; i++) push(i, cyc);
      @(negedge clk);
      chk("scan_busy", 32'(busy_w[0]), 32'd1);
      chk("scan_hold", 32'(hold_w[0]), 32'd1);
      drain(30);
      chk("cs_cycles_n1", 32'(cs_cnt3), 32'd1);
      chk("noauto_busy", 32'(busy_w[4]), 32'd0);
      chk("noauto_done", 32'(done_w[4]), 32'd0);
      chk("noauto_hold", 32'(hold_w[4]), 32'd0);

      // Re-check from DONE, with a start pulse mid-sweep that must be ignored
      pulse(0, 1'b1);
      chk("restart_done", 32'(done_w[0]), 32'd0);
      chk("restart_hold", 32'(hold_w[0]), 32'd1);
      wait_addr2();
      pulse(0, 1'b0);
      drain(30);

      // Reset in the middle of a sweep, then the automatic restart
      pulse(0, 1'b0);
      wait_addr2();
      #2 rst_a = 1'b1;
      #1 chk_reset0();
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      push(0, cyc);
      drain(30);

      // Manual-start instance: first sweep, then re-check from DONE
      pulse(4, 1'b1);
      chk("man_busy", 32'(busy_w[4]), 32'd1);
      chk("man_hold", 32'(hold_w[4]), 32'd1);
      drain(30);
      pulse(4, 1'b1);
      chk("man_redone", 32'(done_w[4]), 32'd0);
      chk("man_rehold", 32'(hold_w[4]), 32'd1);
      drain(30);

      for (int i = 0; i < 5; i++) chk($sformatf("done_edges[%0d]", i), 32'(done_edges[i]), 32'(pushes[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
